wrap_addsub_pipe: RTL and testbench

WRAP_ADDSUB_PIPE -- requirements
Module: wrap_addsub_pipe

---
 rtl/wrap_addsub_pipe.sv | 105 ++++++++++
 tb/tb_wrap_addsub_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wrap_addsub_pipe.sv
// wrap_addsub_pipe: 2-stage add/sub pipeline, modulo-LIMIT correction.
// Ports: clk, rst_n, in_valid/in_ready/mode/a/b in; out_valid/out_ready/result/out_of_range/op_err out.
// Macro WRAP_ADDSUB_WRAP_EN: wrap out-of-range results (default: saturate).
module wrap_addsub_pipe #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_of_range,
  output logic             op_err
);

  localparam logic [WIDTH:0]   LIM  = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(LIMIT - 1);

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  logic           v1;
  logic           mode1;
  logic           err1;
  logic [WIDTH:0] raw1;

  logic [WIDTH:0] a_x;
  logic [WIDTH:0] b_x;
  assign a_x = {1'b0, a};
  assign b_x = {1'b0, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      mode1 <= 1'b0;
      err1  <= 1'b0;
      raw1  <= '0;
    end else if (en) begin
      v1    <= in_valid;
      mode1 <= mode;
      err1  <= (a_x >= LIM) || (b_x >= LIM);
      raw1  <= mode ? a_x - b_x : a_x + b_x;
    end
  end

  // raw1 is unsigned for add, two's complement for sub
  logic             hi;
  logic             lo;
  logic [WIDTH-1:0] res_d;
  logic             oor_d;

  assign hi = !err1 && !mode1 && (raw1 >= LIM);
  assign lo = !err1 && mode1 && raw1[WIDTH];

  always_comb begin
    res_d = '0;
    oor_d = 1'b0;
    unique case (1'b1)
      err1: begin
        res_d = '0;
      end
      hi: begin
        oor_d = 1'b1;
`ifdef WRAP_ADDSUB_WRAP_EN
        res_d = WIDTH'(raw1 - LIM);
`else
        res_d = MAXV;
`endif
      end
      lo: begin
        oor_d = 1'b1;
`ifdef WRAP_ADDSUB_WRAP_EN
        res_d = WIDTH'(raw1 + LIM);
`else
        res_d = '0;
`endif
      end
      default: begin
        res_d = raw1[WIDTH-1:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      result       <= '0;
      out_of_range <= 1'b0;
      op_err       <= 1'b0;
    end else if (en) begin
      out_valid    <= v1;
      result       <= res_d;
      out_of_range <= oor_d;
      op_err       <= err1;
    end
  end

endmodule

// File: tb/tb_wrap_addsub_pipe.sv
// tb_wrap_addsub_pipe: scoreboard bench for wrap_addsub_pipe.
// Reference model is plain integer arithmetic on the modulus.
module tb_wrap_addsub_pipe;

  localparam int W = 5;
  localparam int L = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         out_of_range;
  logic         op_err;

  wrap_addsub_pipe #(.WIDTH(W), .LIMIT(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mode(mode),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .out_of_range(out_of_range),
    .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         oor;
    logic         err;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic exp_t model(logic m, int x, int y);
    exp_t e;
    int raw;
    e = '0;
    if (x >= L || y >= L) begin
      e.err = 1'b1;
      return e;
    end
    raw = m ? x - y : x + y;
    if (raw < 0) begin
      e.oor = 1'b1;
`ifdef WRAP_ADDSUB_WRAP_EN
      e.res = W'(raw + L);
`else
      e.res = '0;
`endif
    end else if (raw >= L) begin
      e.oor = 1'b1;
`ifdef WRAP_ADDSUB_WRAP_EN
      e.res = W'(raw - L);
`else
      e.res = W'(L - 1);
`endif
    end else begin
      e.res = W'(raw);
    end
    return e;
  endfunction

  // monitor / scoreboard
  logic         hold_q = 1'b0;
  logic [W-1:0] held = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold_q = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", result, 0);
      chk("rst_oor", out_of_range, 0);
      chk("rst_op_err", op_err, 0);
    end else begin
      chk("in_ready", in_ready, (!out_valid || out_ready));
      if (hold_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", result, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("out_of_range", out_of_range, e.oor);
          chk("op_err", op_err, e.err);
        end
      end
      if (in_valid && in_ready) q.push_back(model(mode, a, b));
      hold_q = out_valid && !out_ready;
      held = result;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  task automatic send(logic m, int x, int y);
    int n;
    in_valid = 1'b1;
    mode = m;
    a = W'(x);
    b = W'(y);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    cyc();
    in_valid = 1'b0;
  endtask

  int dm[4] = '{1, 0, 0, 0};
  int da[4] = '{3, 19, 7, 25};
  int db[4] = '{5, 1, 12, 1};

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // first op after reset: exactly 2-cycle latency
    cyc();
    in_valid = 1'b1;
    mode = 1'b1;
    a = 5'd3;
    b = 5'd5;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_c1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat1_c2_valid", out_valid, 1);

    // directed back-to-back set
    cyc();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      mode = dm[i][0];
      a = W'(da[i]);
      b = W'(db[i]);
      cyc();
    end
    in_valid = 1'b0;
    drain(20);

    // backpressure: hold first result for 4 cycles
    cyc();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) send(1'b0, i + 2, i + 3);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("stall_seen", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain(20);

    // async reset with two ops in flight
    cyc();
    out_ready = 1'b0;
    in_valid = 1'b1;
    mode = 1'b0;
    a = 5'd4;
    b = 5'd5;
    cyc();
    a = 5'd6;
    b = 5'd7;
    cyc();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end
    cyc();
    in_valid = 1'b1;
    mode = 1'b0;
    a = 5'd7;
    b = 5'd12;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat2_c1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat2_c2_valid", out_valid, 1);
    drain(20);

    // randomized traffic with random backpressure
    cyc();
    repeat (300) begin
      in_valid = ($urandom % 4) != 0;
      mode = 1'($urandom % 2);
      a = W'($urandom_range(0, 22));
      b = W'($urandom_range(0, 22));
      out_ready = ($urandom % 4) != 0;
      cyc();
    end
    drain(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
